// File: rtl/nn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_inference_sequencer
// Purpose  : Runs one inference pass through the input layer and layer 1.
//            It accepts a start request and streams a binary pixel frame into
//            the input layer. It then waits for the layer 1 result, captures
//            it, acknowledges layer 1 and presents the result on a
//            valid/ready port. It also arbitrates the layer 1 weight/bias
//            write port: the loader gets it only while no frame is in flight.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            start                 - inference request (sampled in IDLE)
//            pix_valid/pix_data    - pixel source, pix_ready back-pressure
//            readyForInputs        - input layer can accept a frame
//            inputsInbound/pixelValue - pixel stream to the input layer
//            layer1OutputsReady/layer1Output - layer 1 result
//            outputsRecieved       - one-cycle ack to layer 1
//            result_valid/result_data/result_ready - result port
//            cfg_req/cfg_grant     - weight loader arbitration
//            busy, error           - status (error is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module nn_inference_sequencer #(
   parameter int NUM_PIXELS     = 10,
   parameter int PIX_CNT_WIDTH  = 10,
   parameter int OUT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 pix_valid,
   input  logic                 pix_data,
   output logic                 pix_ready,
   input  logic                 readyForInputs,
   output logic                 inputsInbound,
   output logic                 pixelValue,
   input  logic                 layer1OutputsReady,
   input  logic [OUT_WIDTH-1:0] layer1Output,
   output logic                 outputsRecieved,
   output logic                 result_valid,
   output logic [OUT_WIDTH-1:0] result_data,
   input  logic                 result_ready,
   input  logic                 cfg_req,
   output logic                 cfg_grant,
   output logic                 busy,
   output logic                 error
);

   // One extra bit of headroom so TIMEOUT_CYCLES itself is representable.
   localparam int c_TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PIX_CNT_WIDTH-1:0] c_LAST_PIX  = PIX_CNT_WIDTH'(NUM_PIXELS - 1);
   localparam logic [c_TO_WIDTH-1:0]    c_LAST_WAIT = c_TO_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CFG      = 3'd1,
      WAIT_RDY = 3'd2,
      STREAM   = 3'd3,
      WAIT_L1  = 3'd4,
      PRESENT  = 3'd5,
      ERR      = 3'd6
   } seqState_t;

   seqState_t                r_state;
   seqState_t                w_stateNext;
   logic [PIX_CNT_WIDTH-1:0] r_pixCnt;
   logic [PIX_CNT_WIDTH-1:0] w_pixCntNext;
   logic [c_TO_WIDTH-1:0]    r_waitCnt;
   logic [c_TO_WIDTH-1:0]    w_waitCntNext;

   logic                 r_pixReady;
   logic                 r_inputsInbound;
   logic                 w_inboundNext;
   logic                 r_pixelValue;
   logic                 w_pixelValueNext;
   logic                 r_outputsRecieved;
   logic                 w_ackNext;
   logic                 r_resultValid;
   logic [OUT_WIDTH-1:0] r_resultData;
   logic [OUT_WIDTH-1:0] w_resultDataNext;
   logic                 r_cfgGrant;
   logic                 r_busy;
   logic                 r_error;
   logic                 w_errorNext;

   // ------------------------------------------------------------------------
   // State register plus registered outputs. The state-derived outputs are
   // registered from the next state so that they line up with the state
   // they describe.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state           <= IDLE;
         r_pixCnt          <= '0;
         r_waitCnt         <= '0;
         r_pixReady        <= 1'b0;
         r_inputsInbound   <= 1'b0;
         r_pixelValue      <= 1'b0;
         r_outputsRecieved <= 1'b0;
         r_resultValid     <= 1'b0;
         r_resultData      <= '0;
         r_cfgGrant        <= 1'b0;
         r_busy            <= 1'b0;
         r_error           <= 1'b0;
      end else begin
         r_state           <= w_stateNext;
         r_pixCnt          <= w_pixCntNext;
         r_waitCnt         <= w_waitCntNext;
         r_pixReady        <= (w_stateNext == STREAM);
         r_inputsInbound   <= w_inboundNext;
         r_pixelValue      <= w_pixelValueNext;
         r_outputsRecieved <= w_ackNext;
         r_resultValid     <= (w_stateNext == PRESENT);
         r_resultData      <= w_resultDataNext;
         r_cfgGrant        <= (w_stateNext == CFG);
         r_busy            <= (w_stateNext != IDLE);
         r_error           <= w_errorNext;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic.
   // ------------------------------------------------------------------------
   always_comb begin
      w_stateNext      = r_state;
      w_pixCntNext     = r_pixCnt;
      w_waitCntNext    = r_waitCnt;
      w_inboundNext    = 1'b0;
      w_pixelValueNext = r_pixelValue;
      w_ackNext        = 1'b0;
      w_resultDataNext = r_resultData;
      w_errorNext      = r_error;

      case (r_state)
         IDLE: begin
            // The loader wins a tie; a start in the same cycle is dropped.
            if (cfg_req) begin
               w_stateNext = CFG;
            end else if (start) begin
               w_stateNext  = WAIT_RDY;
               w_errorNext  = 1'b0;
               w_pixCntNext = '0;
            end
         end
         CFG: begin
            if (!cfg_req) begin
               w_stateNext = IDLE;
            end
         end
         WAIT_RDY: begin
            if (readyForInputs) begin
               w_stateNext = STREAM;
            end
         end
         STREAM: begin
            // pix_ready is high for the whole of STREAM, so a transfer
            // is simply pix_valid.
            if (pix_valid) begin
               w_inboundNext    = 1'b1;
               w_pixelValueNext = pix_data;
               w_pixCntNext     = r_pixCnt + 1'b1;
               if (r_pixCnt == c_LAST_PIX) begin
                  w_stateNext   = WAIT_L1;
                  w_waitCntNext = '0;
               end
            end else if (r_pixCnt != '0) begin
               // A gap once the frame has begun would split the frame.
               w_stateNext = ERR;
               w_errorNext = 1'b1;
            end
         end
         WAIT_L1: begin
            // Ready is checked first so that it wins on the final cycle.
            if (layer1OutputsReady) begin
               w_resultDataNext = layer1Output;
               w_ackNext        = 1'b1;
               w_stateNext      = PRESENT;
            end else if (r_waitCnt == c_LAST_WAIT) begin
               w_stateNext = ERR;
               w_errorNext = 1'b1;
            end else begin
               w_waitCntNext = r_waitCnt + 1'b1;
            end
         end
         PRESENT: begin
            if (result_ready) begin
               w_stateNext = IDLE;
            end
         end
         ERR: begin
            // error stays set here; it clears only on the next accepted start.
            if (start) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   assign pix_ready       = r_pixReady;
   assign inputsInbound   = r_inputsInbound;
   assign pixelValue      = r_pixelValue;
   assign outputsRecieved = r_outputsRecieved;
   assign result_valid    = r_resultValid;
   assign result_data     = r_resultData;
   assign cfg_grant       = r_cfgGrant;
   assign busy            = r_busy;
   assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_inference_sequencer
// Purpose  : Self-checking bench for nn_inference_sequencer with a
//            scoreboard. It contains a behavioural layer 1 responder and a
//            reference model of the layer 1 arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_inference_sequencer;

   localparam int c_NUM_PIXELS = 4;
   localparam int c_OUT_WIDTH  = 8;
   localparam int c_TIMEOUT    = 8;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   pix_valid;
   logic                   pix_data;
   logic                   pix_ready;
   logic                   readyForInputs;
   logic                   inputsInbound;
   logic                   pixelValue;
   logic                   layer1OutputsReady;
   logic [c_OUT_WIDTH-1:0] layer1Output;
   logic                   outputsRecieved;
   logic                   result_valid;
   logic [c_OUT_WIDTH-1:0] result_data;
   logic                   result_ready;
   logic                   cfg_req;
   logic                   cfg_grant;
   logic                   busy;
   logic                   error;

   nn_inference_sequencer #(
      .NUM_PIXELS    (c_NUM_PIXELS),
      .PIX_CNT_WIDTH (10),
      .OUT_WIDTH     (c_OUT_WIDTH),
      .TIMEOUT_CYCLES(c_TIMEOUT)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .pix_valid         (pix_valid),
      .pix_data          (pix_data),
      .pix_ready         (pix_ready),
      .readyForInputs    (readyForInputs),
      .inputsInbound     (inputsInbound),
      .pixelValue        (pixelValue),
      .layer1OutputsReady(layer1OutputsReady),
      .layer1Output      (layer1Output),
      .outputsRecieved   (outputsRecieved),
      .result_valid      (result_valid),
      .result_data       (result_data),
      .result_ready      (result_ready),
      .cfg_req           (cfg_req),
      .cfg_grant         (cfg_grant),
      .busy              (busy),
      .error             (error)
   );

   always #5 clk = ~clk;

   int               nChecks = 0;
   int               nFails  = 0;
   logic [7:0]       expQ[$];
   int               ackCount = 0;
   int               inbCount = 0;
   bit               grantForbidden = 1'b0;
   bit               l1Mute = 1'b0;
   int               forcedDelay = -1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Layer 1 reference: two ReLU nodes, 4-bit saturated outputs,
   // node 0 in the upper nibble. Pixel i is bit i.
   function automatic logic [7:0] layer1Model(input logic [c_NUM_PIXELS-1:0] pix);
      int w0[4] = '{3, 5, 1, 5};
      int w1[4] = '{0, 6, -7, 2};
      int s0 = 0;
      int s1 = 0;
      for (int i = 0; i < c_NUM_PIXELS; i++) begin
         if (pix[i]) begin
            s0 += w0[i];
            s1 += w1[i];
         end
      end
      if (s0 < 0) s0 = 0;
      if (s0 > 15) s0 = 15;
      if (s1 < 0) s1 = 0;
      if (s1 > 15) s1 = 15;
      return {4'(s0), 4'(s1)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: event counters, grant hold-off and scoreboard pop.
   always @(negedge clk) begin
      if (!reset) begin
         if (outputsRecieved) ackCount++;
         if (inputsInbound) inbCount++;
         if (grantForbidden) check("cfg_grant during frame", {31'd0, cfg_grant}, 32'd0);
         if (result_valid && result_ready) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL scoreboard: result 0x%0h with no expected entry", result_data);
            end else begin
               check("result_data", {24'd0, result_data}, {24'd0, expQ.pop_front()});
            end
         end
      end
   end

   // Layer 1 responder: collects the streamed frame, then answers after a delay.
   initial begin
      logic [c_NUM_PIXELS-1:0] cap;
      int cnt;
      int delay;
      bit armed;
      cap = '0;
      cnt = 0;
      delay = 0;
      armed = 1'b0;
      layer1OutputsReady = 1'b0;
      layer1Output = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || !busy) begin
            cnt = 0;
            armed = 1'b0;
            layer1OutputsReady = 1'b0;
         end else begin
            if (outputsRecieved) layer1OutputsReady = 1'b0;
            if (inputsInbound && cnt < c_NUM_PIXELS) begin
               cap[cnt] = pixelValue;
               cnt++;
               if (cnt == c_NUM_PIXELS) begin
                  armed = !l1Mute;
                  delay = (forcedDelay >= 0) ? forcedDelay : int'($urandom_range(0, 5));
               end
            end else if (armed) begin
               if (delay == 0) begin
                  layer1OutputsReady = 1'b1;
                  layer1Output = layer1Model(cap);
                  armed = 1'b0;
               end else begin
                  delay--;
               end
            end
         end
      end
   end

   task automatic checkAllZero(input string name);
      check(name, {17'd0, pix_ready, inputsInbound, pixelValue, outputsRecieved, result_valid,
                   result_data, cfg_grant, busy, error}, 32'd0);
   endtask

   task automatic runFrame(input logic [c_NUM_PIXELS-1:0] pix, input int preGap,
                           input int rrDelay, input bit cfgDuring);
      logic [7:0] exp;
      int acks0;
      int inb0;
      int n;
      exp = layer1Model(pix);
      acks0 = ackCount;
      inb0 = inbCount;
      result_ready = (rrDelay == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("error cleared by start", {31'd0, error}, 32'd0);
      check("pix_ready 1 cycle after start", {31'd0, pix_ready}, 32'd0);
      tick();
      check("pix_ready 2 cycles after start", {31'd0, pix_ready}, 32'd1);
      expQ.push_back(exp);
      grantForbidden = 1'b1;
      if (cfgDuring) cfg_req = 1'b1;
      repeat (preGap) tick();
      check("inputsInbound before first pixel", {31'd0, inputsInbound}, 32'd0);
      for (int i = 0; i < c_NUM_PIXELS; i++) begin
         pix_valid = 1'b1;
         pix_data = pix[i];
         tick();
      end
      pix_valid = 1'b0;
      pix_data = 1'b0;
      check("pix_ready drops after last pixel", {31'd0, pix_ready}, 32'd0);
      check("inputsInbound on last pixel", {31'd0, inputsInbound}, 32'd1);
      tick();
      check("inputsInbound low after last pixel", {31'd0, inputsInbound}, 32'd0);
      n = 0;
      while (!result_valid && n < 40) begin
         tick();
         n++;
      end
      check("result_valid within budget", {31'd0, result_valid}, 32'd1);
      check("ack with first result_valid", {31'd0, outputsRecieved}, 32'd1);
      for (int k = 0; k < rrDelay; k++) begin
         check("result_valid held", {31'd0, result_valid}, 32'd1);
         check("result_data held", {24'd0, result_data}, {24'd0, exp});
         tick();
      end
      result_ready = 1'b1;
      tick();
      check("result_valid drops after accept", {31'd0, result_valid}, 32'd0);
      check("busy low after accept", {31'd0, busy}, 32'd0);
      result_ready = 1'b0;
      grantForbidden = 1'b0;
      tick();
      if (cfgDuring) begin
         check("cfg_grant after frame", {31'd0, cfg_grant}, 32'd1);
         cfg_req = 1'b0;
         tick();
         check("cfg_grant released", {31'd0, cfg_grant}, 32'd0);
      end
      check("one ack per frame", ackCount - acks0, 32'd1);
      check("inputsInbound cycles per frame", inbCount - inb0, c_NUM_PIXELS);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks0;
      int n;
      reset = 1'b1;
      start = 1'b0;
      pix_valid = 1'b0;
      pix_data = 1'b0;
      readyForInputs = 1'b1;
      result_ready = 1'b0;
      cfg_req = 1'b0;
      tick();
      tick();
      checkAllZero("reset outputs");
      reset = 1'b0;
      tick();
      checkAllZero("idle after reset");

      // Nominal frame and backpressure.
      runFrame(4'b0110, 0, 0, 1'b0);
      runFrame(4'b0110, 0, 5, 1'b0);

      // Arbitration: cfg_req beats a simultaneous start.
      cfg_req = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("cfg_grant on tie", {31'd0, cfg_grant}, 32'd1);
      check("busy in cfg", {31'd0, busy}, 32'd1);
      check("no pix_ready in cfg", {31'd0, pix_ready}, 32'd0);
      tick();
      check("cfg_grant held", {31'd0, cfg_grant}, 32'd1);
      cfg_req = 1'b0;
      tick();
      check("cfg_grant low back in idle", {31'd0, cfg_grant}, 32'd0);
      check("busy low back in idle", {31'd0, busy}, 32'd0);
      tick();
      tick();
      check("dropped start stays idle", {30'd0, busy, pix_ready}, 32'd0);
      runFrame(4'($urandom), 1, 2, 1'b1);

      // Underrun after two pixels.
      acks0 = ackCount;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      pix_valid = 1'b1;
      pix_data = 1'b0;
      tick();
      pix_data = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      check("underrun error", {31'd0, error}, 32'd1);
      check("underrun inputsInbound", {31'd0, inputsInbound}, 32'd0);
      check("underrun pix_ready", {31'd0, pix_ready}, 32'd0);
      check("underrun busy", {31'd0, busy}, 32'd1);
      tick();
      check("error sticky in ERR", {31'd0, error}, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ERR exits to idle", {31'd0, busy}, 32'd0);
      check("error kept until next start", {31'd0, error}, 32'd1);
      check("no ack on underrun", ackCount - acks0, 32'd0);
      runFrame(4'b0110, 0, 0, 1'b0);

      // Layer 1 ready on the final allowed wait cycle still wins.
      forcedDelay = c_TIMEOUT - 2;
      runFrame(4'($urandom), 0, 1, 1'b0);
      forcedDelay = -1;

      // Timeout with layer 1 silent.
      l1Mute = 1'b1;
      acks0 = ackCount;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < c_NUM_PIXELS; i++) begin
         pix_valid = 1'b1;
         pix_data = 1'($urandom);
         tick();
      end
      pix_valid = 1'b0;
      check("entered wait for layer 1", {31'd0, pix_ready}, 32'd0);
      n = 0;
      while (!error && n < 20) begin
         tick();
         n++;
      end
      check("timeout cycles", n, c_TIMEOUT);
      check("timeout busy", {31'd0, busy}, 32'd1);
      check("timeout no result", {31'd0, result_valid}, 32'd0);
      check("no ack on timeout", ackCount - acks0, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("timeout ERR exits", {31'd0, busy}, 32'd0);
      l1Mute = 1'b0;

      // Reset in the middle of a frame.
      acks0 = ackCount;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      pix_valid = 1'b1;
      pix_data = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checkAllZero("mid-frame reset outputs");
      reset = 1'b0;
      pix_valid = 1'b0;
      pix_data = 1'b0;
      tick();
      check("no ack on reset", ackCount - acks0, 32'd0);
      runFrame(4'b0110, 0, 0, 1'b0);

      // Randomised frames.
      for (int f = 0; f < 20; f++) begin
         runFrame(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)));
      end

      check("scoreboard drained", expQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
